// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1 - 8N1 UART transmitter (optional parity) with a one-entry
// holding buffer, fed by the continuous-sensing controller.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   data_in    byte to send, sampled when a request is accepted
//   data_send  send request; only a rising edge counts as a request
//   tx         serial line, idle high
//   done_tx    high when idle and the holding buffer is empty
//   busy       high while a frame is on the line
//   overrun    one-cycle pulse when a request is dropped (buffer full)
module uart_tx_8n1 #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,  // must be >= 2
  parameter logic        PARITY_EN    = 1'b0,
  parameter logic        PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_send,
  output logic       tx,
  output logic       done_tx,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          buf_full_q, buf_full_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic          send_q;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;

  logic          req, req_taken, bit_end, load;
  logic [7:0]    load_byte;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    ovr_d      = 1'b0;
    load       = 1'b0;
    load_byte  = data_in;
    req_taken  = 1'b0;
    tx_d       = 1'b1;

    req     = data_send & ~send_q;
    bit_end = (baud_q == BIT_LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          load      = 1'b1;
          req_taken = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (buf_full_q) begin
            load       = 1'b1;
            load_byte  = buf_data_q;
            buf_full_d = 1'b0;
          end else if (req) begin
            load      = 1'b1;
            req_taken = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_START;
      shreg_d = load_byte;
      par_d   = (^load_byte) ^ PARITY_ODD;
      bit_d   = '0;
      baud_d  = '0;
    end

    // Requests not consumed above arrive mid-frame. Checking buf_full_d lets a
    // request coinciding with the buffer draining at stop-end refill it.
    if (req && !req_taken) begin
      if (!buf_full_d) begin
        buf_full_d = 1'b1;
        buf_data_d = data_in;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // tx is registered from the next-state view so it changes on the same
    // edge as the state transition.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    done_d = (state_d == S_IDLE) && !buf_full_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      send_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      send_q     <= data_send;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx      = tx_q;
  assign done_tx = done_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1 - self-checking bench for uart_tx_8n1 (CLKS_PER_BIT=10).
// Main instance without parity, plus even- and odd-parity instances.
module tb_uart_tx_8n1;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_send;
  logic       tx, done_tx, busy, overrun;

  logic [7:0] p_data;
  logic       p_send;
  logic       pe_tx, pe_done, pe_busy, pe_ovr;
  logic       po_tx, po_done, po_busy, po_ovr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frames_seen = 0;
  logic mon_en = 1'b1;

  logic [7:0] sb_q[$];
  int         start_q[$];

  uart_tx_8n1 #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_send(data_send),
    .tx(tx), .done_tx(done_tx), .busy(busy), .overrun(overrun)
  );

  uart_tx_8n1 #(.CLK_HZ(1000), .BAUD(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk(clk), .rst(rst), .data_in(p_data), .data_send(p_send),
    .tx(pe_tx), .done_tx(pe_done), .busy(pe_busy), .overrun(pe_ovr)
  );

  uart_tx_8n1 #(.CLK_HZ(1000), .BAUD(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk(clk), .rst(rst), .data_in(p_data), .data_send(p_send),
    .tx(po_tx), .done_tx(po_done), .busy(po_busy), .overrun(po_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: samples every clock of a 10-bit frame, checks each bit is
  // stable for CPB clocks, then compares the byte against the scoreboard.
  initial begin : monitor
    logic [9:0] fr;
    logic       stable;
    logic [7:0] expb;
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        stable = 1'b1;
        fr     = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) fr[b] = tx;
            else if (tx !== fr[b]) stable = 1'b0;
          end
        end
        frames_seen++;
        chk("bit_timing", int'(stable), 1);
        chk("start_bit", int'(fr[0]), 0);
        chk("stop_bit", int'(fr[9]), 1);
        chk("sb_has_entry", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          expb = sb_q.pop_front();
          chk("frame_byte", int'(fr[8:1]), int'(expb));
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    int         hold;     // clocks data_send stays high
    int         exp_low;  // expected clocks done_tx stays low
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int n, low, ovr_cnt, ovr_at, sz;
    logic [10:0] pf_e, pf_o, exp_e, exp_o;

    vecs[0] = '{8'hA5, 1,   100};
    vecs[1] = '{8'h3C, 300, 100};
    vecs[2] = '{8'h00, 1,   100};
    vecs[3] = '{8'hFF, 1,   100};
    vecs[4] = '{8'h81, 5,   100};

    rst = 1'b0; data_in = '0; data_send = 1'b0; p_data = '0; p_send = 1'b0;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("in_reset", int'({tx, done_tx, busy, overrun}), 'b1100);
    end
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("idle", int'({tx, done_tx, busy, overrun}), 'b1100);
    end

    // Table-driven single frames; data_in is scrambled after acceptance
    for (int v = 0; v < 5; v++) begin
      data_in = vecs[v].data; data_send = 1'b1;
      sb_q.push_back(vecs[v].data);
      n = 0; low = 0;
      do begin
        @(negedge clk); n++;
        if (n == 1) begin
          chk("accept_tx_busy", int'({tx, busy, done_tx}), 'b010);
          data_in = ~vecs[v].data;
        end
        if (n >= vecs[v].hold) data_send = 1'b0;
        if (done_tx == 1'b0) low++;
      end while ((done_tx == 1'b0 || n < vecs[v].hold) && n < 1000);
      chk("done_low_clks", low, vecs[v].exp_low);
      repeat (5) @(negedge clk);
    end

    // Buffered request at 30, overrun at 40, back-to-back frames
    data_in = 8'h11; data_send = 1'b1; sb_q.push_back(8'h11);
    low = 0; ovr_cnt = 0; ovr_at = -1;
    for (n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (done_tx == 1'b0) low++;
      if (overrun == 1'b1) begin ovr_cnt++; ovr_at = n; end
      if (n == 1 || n == 31 || n == 41) data_send = 1'b0;
      if (n == 30) begin data_in = 8'h22; data_send = 1'b1; sb_q.push_back(8'h22); end
      if (n == 40) begin data_in = 8'h33; data_send = 1'b1; end
      if (n == 41) data_in = 8'h55;
    end
    chk("buf_done_low", low, 200);
    chk("overrun_pulses", ovr_cnt, 1);
    chk("overrun_when", ovr_at, 41);
    sz = start_q.size();
    chk("buf_no_gap", start_q[sz-1] - start_q[sz-2], 10 * CPB);

    // Request on the final STOP clock with an empty buffer
    data_in = 8'h5A; data_send = 1'b1; sb_q.push_back(8'h5A);
    low = 0; ovr_cnt = 0;
    for (n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (done_tx == 1'b0) low++;
      if (overrun == 1'b1) ovr_cnt++;
      if (n == 1 || n == 101) data_send = 1'b0;
      if (n == 100) begin data_in = 8'hC3; data_send = 1'b1; sb_q.push_back(8'hC3); end
    end
    chk("stopend_done_low", low, 200);
    chk("stopend_overrun", ovr_cnt, 0);
    sz = start_q.size();
    chk("stopend_no_gap", start_q[sz-1] - start_q[sz-2], 10 * CPB);

    // Parity instances, data 0x07: even parity bit 1, odd parity bit 0
    p_data = 8'h07; p_send = 1'b1;
    low = 0; pf_e = '0; pf_o = '0;
    for (n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (n == 1) p_send = 1'b0;
      if (pe_done == 1'b0) low++;
      if (n >= 1 && n <= 110 && ((n - 1) % CPB) == 5) begin
        pf_e[(n - 1) / CPB] = pe_tx;
        pf_o[(n - 1) / CPB] = po_tx;
      end
    end
    exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
    exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
    chk("parity_even_frame", int'(pf_e), int'(exp_e));
    chk("parity_odd_frame", int'(pf_o), int'(exp_o));
    chk("parity_done_low", low, 110);

    // Reset mid-frame: tx must return high with no clock edge
    mon_en = 1'b0;
    data_in = 8'hF0; data_send = 1'b1;
    for (n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) data_send = 1'b0;
    end
    chk("pre_reset_tx", int'({tx, busy}), 'b01);
    #2 rst = 1'b0;
    #1 chk("async_reset", int'({tx, done_tx, busy, overrun}), 'b1100);
    @(negedge clk);
    data_in = 8'h96; data_send = 1'b1;
    @(negedge clk);
    chk("reset_hold", int'({tx, done_tx, busy, overrun}), 'b1100);

    // data_send held high across reset release: exactly one frame
    rst = 1'b1; mon_en = 1'b1; sb_q.push_back(8'h96);
    low = 0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) chk("release_accept", int'({tx, busy}), 'b01);
      if (done_tx == 1'b0) low++;
    end
    chk("release_done_low", low, 100);
    data_send = 1'b0;
    repeat (5) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    chk("frames_total", frames_seen, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial transmitter directly downstream of the continuous-sensing controller.
- Takes the 8-bit sensor byte and its send strobe, and serialises the byte onto the UART TX pin as 8N1 (optional parity) at a fixed baud.
- Returns done_tx to the controller so it only launches a new reading when the line is idle.
- Provides a one-entry holding buffer so a request arriving mid-frame is not lost.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (5208), clocks per serial bit; must be >= 2.
- PARITY_EN, 0, 1 inserts a parity bit between D7 and stop.
- PARITY_ODD, 0, 1 selects odd parity, 0 even (ignored when PARITY_EN=0).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to transmit; sampled when a request is accepted.
- data_send  input  1  send request; only its rising edge (data_send=1 while previous-cycle sample=0) is a request.
- tx  output  1  serial line, idle high.
- done_tx  output  1  high when the FSM is IDLE and the holding buffer is empty.
- busy  output  1  high while a frame is on the line (state != IDLE).
- overrun  output  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, done_tx=1, busy=0, overrun=0, state=IDLE, buffer empty, baud counter=0, bit counter=0, data_send edge register=0.
- Reset mid-frame aborts the frame; tx returns to 1 immediately without waiting for a clock.
- data_send held high across reset release produces one request on the first clock edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a request, latch data_in into the shift register and enter START. tx=0 and busy=1 take effect at that same edge. done_tx falls at that edge.
- Each of START, DATA-bit, PARITY and STOP holds tx for exactly CLKS_PER_BIT clocks. The baud counter counts 0..CLKS_PER_BIT-1 and rolls over on bit completion.
- DATA: LSB first, D0..D7; 3-bit bit counter. After D7 go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR(data) for even parity, ~XOR(data) for odd.
- STOP: tx=1 for one bit time. At its final clock:
  - buffer full: load the buffered byte, clear the buffer, enter START (tx=0 at that edge, no idle gap);
  - buffer empty, no request: enter IDLE, busy=0, done_tx=1;
  - buffer empty, request on that same edge: the request byte goes straight to START; it is not buffered.
- Frame length is 10*CLKS_PER_BIT clocks (11*CLKS_PER_BIT with parity), measured from the edge tx falls to the edge the next frame or idle begins.
- Request while busy=1 (other than the stop-end case above):
  - buffer empty: data_in is stored in the buffer; done_tx stays 0.
  - buffer full: request dropped, buffered byte unchanged, overrun=1 for exactly one cycle.
- data_in changes after acceptance have no effect on the frame in flight.
- All outputs are registered; no combinational path from inputs to tx.

Test Plan (CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10, PARITY_EN=0 unless stated):
- Reset, no activity -> tx=1, done_tx=1, busy=0, overrun=0 indefinitely. Assert rst low mid-frame -> tx=1 with no clock edge.
- data_in=0xA5, one rising edge of data_send -> tx=0 for 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, then 1 for 10 clks. done_tx=0 for exactly 100 clks, then 1.
- data_send held high for 300 clks with data_in=0x3C -> exactly one frame sent (no repeat while level held).
- Request 0x11, then 0x22 at clk 30, then 0x33 at clk 40 -> frames 0x11 and 0x22 sent back-to-back with no idle gap. 0x33 dropped with a 1-clk overrun pulse at clk 40. done_tx rises only after the 0x22 stop bit.
- Request coinciding with the final STOP clock of a frame, buffer empty -> new frame's start bit begins at that edge, no idle gap, overrun=0.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit 1, frame 110 clks. PARITY_ODD=1 -> parity bit 0.
